adder_pipe: RTL and testbench
=============================

# adder_pipe

Parametrised, pipelined ripple-slice adder/subtractor: NUM_SLICES slices of SLICE_W bits each. Each slice sits in its own pipeline stage, and the carry is registered between stages. Sustained throughput is one operation per clock at a clock rate set by a single slice rather than the full width. It is the pipelined successor of the fixed 24-bit, three-slice combinational adder. It adds a valid/ready handshake with backpressure, a subtract mode, and carry-out and signed-overflow flags.

## Interface
- SLICE_W, 8: bits per slice and per pipeline stage; must be ≥ 1.
- NUM_SLICES, 3: number of slices, which equals the number of stages; must be ≥ 1. Total width W = SLICE_W*NUM_SLICES (default 24).
- clk  in  1  clock; all state updates on the rising edge.
- rst  in  1  asynchronous, active-high reset.
- in_valid  in  1  input operation present.
- in_ready  out  1  block can accept this cycle.
- a  in  W  operand A, unsigned or two's complement.
- b  in  W  operand B.
- cin  in  1  carry-in when sub=0; borrow-in when sub=1.
- sub  in  1  0 = add, 1 = subtract.
- out_valid  out  1  result present.
- out_ready  in  1  consumer accepts the result.
- s  out  W  result.
- cout  out  1  carry-out of the MSB slice; for subtract, 1 means no borrow.
- ovf  out  1  signed overflow.

## Operation
- Effective operation:
  - sub=0: s = a + b + cin.
  - sub=1: s = a + ~b + ~cin, which equals a − b − cin.
  - The effective carry-in is cin XOR sub.
  - Both are modulo 2^W. cout is bit W of the full sum.
- ovf = (A_msb == B'_msb) && (S_msb != A_msb), where B' is the effective (possibly inverted) b.
- Stage k (0..NUM_SLICES-1):
  - Adds slice k of a and B' plus the carry registered from stage k-1 (stage 0 uses the effective carry-in).
  - Registers the slice-k sum, its carry, and a valid bit.
- Upper operand slices not yet consumed are carried forward in skew registers.
- Lower result slices already produced are carried forward in deskew registers.
- All W result bits of one operation emerge together.
- The operation's sub/MSB information needed for ovf travels with it to the final stage.
- Global advance enable: en = !out_valid || out_ready.
  - in_ready = en. This is combinational from out_valid and out_ready; it does not depend on in_valid.
  - When en=1, every stage register loads from its predecessor; stage 0 loads the input and v0 <= in_valid.
  - When en=0, all pipeline registers, including valid bits, hold.
- Bubbles: invalid stages still shift, so a gap in input produces a gap at the output. Data in invalid stages is don't-care, but no X may reach s/cout/ovf while out_valid=1.
- Order is strictly preserved; no operation is dropped or duplicated.

## Timing
- Latency: an operation accepted at rising edge t (in_valid && in_ready) presents out_valid=1 with its result from edge t+NUM_SLICES−1 onward. With NUM_SLICES=1 it appears immediately after edge t. Default latency is 3 edges (result valid from edge t+2), assuming no stall.
- Stalls extend latency by exactly the number of cycles with en=0.
- Throughput: one accept per cycle while out_ready stays high.
- Output hold: while out_valid=1 and out_ready=0, s/cout/ovf are stable and in_ready=0.
- Simultaneous events: with out_valid=1, out_ready=1 and in_valid=1 in the same cycle, the output retires and the input enters in that same edge.
- Reset (asynchronous, any time, including mid-stream): all valid bits clear immediately and all data/carry registers go to 0. Consequently out_valid=0, s=0, cout=0, ovf=0, and in_ready=1 after reset asserts. In-flight operations are discarded.
- The first accept is possible on the first rising edge after rst deasserts.
- Critical path is one SLICE_W-bit ripple plus a register; no path spans two slices.

## Test plan
- Carry across every slice (defaults): a=24'hFFFFFF, b=24'h000001, cin=0, sub=0 → s=24'h000000, cout=1, ovf=0, out_valid exactly 3 edges after accept.
- Subtract with borrow: a=24'h000010, b=24'h000020, cin=0, sub=1 → s=24'hFFFFF0, cout=0, ovf=0. Then a=24'h800000, b=24'h000001, sub=1 → s=24'h7FFFFF, ovf=1, cout=1.
- Signed overflow on add: a=24'h7FFFFF, b=24'h000001, cin=0 → s=24'h800000, ovf=1, cout=0. Then a=24'h000005, b=24'h000003, cin=1 → s=24'h000009.
- Streaming with backpressure: 20 random back-to-back operations, out_ready randomly toggled ~50% → results match the reference model in order, and outputs are stable while out_ready=0. in_ready=0 exactly when out_valid=1 and out_ready=0.
- Reset mid-stream: assert rst with 3 operations in flight → out_valid falls asynchronously and s/cout/ovf=0. After release, the next operation (a=1, b=2) yields s=3 with no stale result emitted.
- Parameter sweep: (SLICE_W, NUM_SLICES) = (1,1), (4,5), (16,2) with random operations → bit-exact results, and latency equals NUM_SLICES edges.

Source files
------------

// File: rtl/adder_pipe_if.sv
// ----------------------------------------------------------------------------
// adder_pipe_if
// Handshake and data bundle for the pipelined adder/subtractor.
//   W          : operand/result width (SLICE_W * NUM_SLICES of the adder)
//   in_valid   : producer has an operation on a/b/cin/sub
//   in_ready   : adder accepts an operation this cycle
//   a, b       : operands (unsigned or two's complement)
//   cin        : carry-in (add) or borrow-in (subtract)
//   sub        : 0 = add, 1 = subtract
//   out_valid  : result present on s/cout/ovf
//   out_ready  : consumer takes the result this cycle
//   s          : result, cout : MSB carry (1 = no borrow on subtract)
//   ovf        : signed overflow
// master = producer/consumer side, slave = the adder.
// ----------------------------------------------------------------------------
interface adder_pipe_if #(
    parameter int W = 24
);
    logic         in_valid;
    logic         in_ready;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic         cin;
    logic         sub;
    logic         out_valid;
    logic         out_ready;
    logic [W-1:0] s;
    logic         cout;
    logic         ovf;

    modport master (
        output in_valid, a, b, cin, sub, out_ready,
        input  in_ready, out_valid, s, cout, ovf
    );

    modport slave (
        input  in_valid, a, b, cin, sub, out_ready,
        output in_ready, out_valid, s, cout, ovf
    );
endinterface

// File: rtl/adder_pipe.sv
// ----------------------------------------------------------------------------
// adder_pipe
// Pipelined ripple-slice adder/subtractor. NUM_SLICES stages of SLICE_W bits;
// stage k adds slice k of the operands plus the carry registered by stage k-1,
// so the critical path is a single SLICE_W-bit ripple.
// Ports:
//   clk : clock, rising edge
//   rst : asynchronous active-high reset, clears every pipeline register
//   bus : adder_pipe_if slave (valid/ready in, valid/ready out, a/b/cin/sub,
//         s/cout/ovf). The whole pipe advances when !out_valid || out_ready.
// ----------------------------------------------------------------------------
module adder_pipe #(
    parameter int SLICE_W    = 8,
    parameter int NUM_SLICES = 3
) (
    input  logic         clk,
    input  logic         rst,
    adder_pipe_if.slave  bus
);
    localparam int W = SLICE_W * NUM_SLICES;

    // One pipeline stage. 'word' is a rotating register: its low slice is the
    // next A slice to consume, and each stage pushes its sum slice in at the
    // top while shifting the rest down. After the last stage it holds exactly
    // the W-bit result in order. 'bop' carries the remaining B' slices,
    // shifted down the same way. 'ovf' is evaluated at every stage from that
    // stage's slice MSBs; only the last stage's value (true MSB) is used.
    typedef struct packed {
        logic         v;
        logic         c;
        logic         ovf;
        logic [W-1:0] word;
        logic [W-1:0] bop;
    } stage_t;

    stage_t             src  [NUM_SLICES];  // stage inputs
    stage_t             st_d [NUM_SLICES];
    stage_t             st_q [NUM_SLICES];
    logic [SLICE_W:0]   slice_sum [NUM_SLICES];
    logic               en;

    // Global advance: the output register frees up when empty or consumed.
    assign en           = !st_q[NUM_SLICES-1].v || bus.out_ready;
    assign bus.in_ready = en;

    always_comb begin
        // Stage 0 sees the raw operation; subtract is a + ~b + ~cin.
        src[0].v    = bus.in_valid;
        src[0].c    = bus.cin ^ bus.sub;
        src[0].ovf  = 1'b0;
        src[0].word = bus.a;
        src[0].bop  = bus.sub ? ~bus.b : bus.b;
        for (int k = 1; k < NUM_SLICES; k++) begin
            src[k] = st_q[k-1];
        end
    end

    always_comb begin
        for (int k = 0; k < NUM_SLICES; k++) begin
            slice_sum[k] = {1'b0, src[k].word[SLICE_W-1:0]}
                         + {1'b0, src[k].bop[SLICE_W-1:0]}
                         + {{SLICE_W{1'b0}}, src[k].c};
            // NOTE: hold is the default so every path assigns st_d; no latch.
            st_d[k] = st_q[k];
            if (en) begin
                st_d[k].v    = src[k].v;
                st_d[k].c    = slice_sum[k][SLICE_W];
                st_d[k].ovf  = (src[k].word[SLICE_W-1] == src[k].bop[SLICE_W-1]) &&
                               (slice_sum[k][SLICE_W-1] != src[k].word[SLICE_W-1]);
                st_d[k].word = W'({slice_sum[k][SLICE_W-1:0], src[k].word} >> SLICE_W);
                st_d[k].bop  = src[k].bop >> SLICE_W;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            // NOTE: data and carry registers are reset along with the valid
            // bits so s/cout/ovf read 0 (never X) right after reset.
            for (int k = 0; k < NUM_SLICES; k++) begin
                st_q[k] <= '0;
            end
        end else begin
            // NOTE: non-blocking so every stage samples its predecessor's old value.
            for (int k = 0; k < NUM_SLICES; k++) begin
                st_q[k] <= st_d[k];
            end
        end
    end

    assign bus.out_valid = st_q[NUM_SLICES-1].v;
    assign bus.s         = st_q[NUM_SLICES-1].word;
    assign bus.cout      = st_q[NUM_SLICES-1].c;
    assign bus.ovf       = st_q[NUM_SLICES-1].ovf;

endmodule

// File: tb/tb_adder_pipe.sv
// ----------------------------------------------------------------------------
// tb_adder_pipe
// Directed corner cases and mid-stream reset on a default 8x3 adder, plus a
// randomized backpressured stream on four configurations (1x1, 4x5, 16x2, 8x3)
// checked cycle by cycle against an arithmetic reference model.
// ----------------------------------------------------------------------------
module tb_adder_pipe;
    localparam int NOPS = 24;

    logic clk = 1'b0;
    logic rst;
    logic start = 1'b0;
    int   n_checks = 0;
    int   n_fail   = 0;

    always #5 clk = ~clk;

    typedef struct {
        logic [63:0] val;
        int          age;
    } inflight_t;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Reference: plain integer arithmetic. Packed as {cout, ovf, s[31:0]}.
    function automatic logic [63:0] ref_op(input int w, input longint a, input longint b,
                                           input bit cin, input bit sub);
        longint m, sa, sb, full, sig;
        bit     co, ov;
        m  = 64'sd1 << w;
        sa = (a >= m / 2) ? a - m : a;
        sb = (b >= m / 2) ? b - m : b;
        if (!sub) begin
            full = a + b + longint'(cin);
            co   = (full >= m);
            sig  = sa + sb + longint'(cin);
        end else begin
            full = a - b - longint'(cin);
            co   = (full >= 0);
            sig  = sa - sb - longint'(cin);
        end
        ov = (sig < -(m / 2)) || (sig > m / 2 - 1);
        return 64'(full & (m - 1)) | (64'(ov) << 32) | (64'(co) << 33);
    endfunction

    // ---------------- default instance for directed tests ----------------
    adder_pipe_if #(.W(24)) bus0 ();
    adder_pipe #(.SLICE_W(8), .NUM_SLICES(3)) u_dut0 (.clk(clk), .rst(rst), .bus(bus0));

    task automatic do_op(input string tag, input logic [23:0] a, input logic [23:0] b,
                         input logic cin, input logic sub,
                         input logic [23:0] es, input logic ec, input logic eo);
        int lat;
        bus0.a = a; bus0.b = b; bus0.cin = cin; bus0.sub = sub;
        bus0.in_valid  = 1'b1;
        bus0.out_ready = 1'b1;
        @(posedge clk); #1;
        bus0.in_valid = 1'b0;
        lat = 1;
        while (!bus0.out_valid && lat < 20) begin
            @(posedge clk); #1;
            lat++;
        end
        check({tag, " latency"}, 64'(lat), 64'd3);
        check({tag, " s"},       64'(bus0.s), 64'(es));
        check({tag, " cout"},    64'(bus0.cout), 64'(ec));
        check({tag, " ovf"},     64'(bus0.ovf), 64'(eo));
        @(posedge clk); #1;
    endtask

    // ---------------- parameter sweep with random streams ----------------
    for (genvar g = 0; g < 4; g++) begin : g_sweep
        localparam int SW = (g == 0) ? 1 : (g == 1) ? 4 : (g == 2) ? 16 : 8;
        localparam int NS = (g == 0) ? 1 : (g == 1) ? 5 : (g == 2) ? 2  : 3;
        localparam int W  = SW * NS;

        bit done = 1'b0;

        adder_pipe_if #(.W(W)) bus ();
        adder_pipe #(.SLICE_W(SW), .NUM_SLICES(NS)) u_dut (.clk(clk), .rst(rst), .bus(bus));

        initial begin
            inflight_t   q [$];
            longint      m, a_v, b_v;
            bit          cin_v, sub_v, exp_v, exp_rdy, acc;
            logic [63:0] obs;
            int          sent, got, budget;
            string       cfg;
            cfg = $sformatf("cfg%0dx%0d", SW, NS);
            m   = 64'sd1 << W;
            bus.in_valid = 1'b0; bus.a = '0; bus.b = '0; bus.cin = 1'b0; bus.sub = 1'b0;
            bus.out_ready = 1'b1;
            sent = 0; got = 0; budget = 0;
            a_v = 0; b_v = 0; cin_v = 0; sub_v = 0;
            wait (start);
            @(posedge clk); #1;
            while (got < NOPS && budget < 2000) begin
                if (!bus.in_valid && sent < NOPS && $urandom_range(0, 4) != 0) begin
                    a_v   = longint'($urandom) & (m - 1);
                    b_v   = longint'($urandom) & (m - 1);
                    cin_v = 1'($urandom_range(0, 1));
                    sub_v = 1'($urandom_range(0, 1));
                    bus.a = a_v[W-1:0]; bus.b = b_v[W-1:0];
                    bus.cin = cin_v; bus.sub = sub_v;
                    bus.in_valid = 1'b1;
                end
                @(negedge clk);
                budget++;
                exp_v   = (q.size() > 0) && (q[0].age == NS - 1);
                exp_rdy = !exp_v || bus.out_ready;
                check({cfg, " out_valid"}, 64'(bus.out_valid), 64'(exp_v));
                check({cfg, " in_ready"},  64'(bus.in_ready),  64'(exp_rdy));
                if (exp_v) begin
                    obs = 64'(bus.s) | (64'(bus.ovf) << 32) | (64'(bus.cout) << 33);
                    check({cfg, " result"}, obs, q[0].val);
                end
                acc = bus.in_valid && exp_rdy;
                @(posedge clk); #1;
                if (exp_rdy) begin
                    if (exp_v) begin
                        void'(q.pop_front());
                        got++;
                    end
                    foreach (q[i]) q[i].age++;
                    if (acc) begin
                        q.push_back('{val: ref_op(W, a_v, b_v, cin_v, sub_v), age: 0});
                        sent++;
                        bus.in_valid = 1'b0;
                    end
                end
                bus.out_ready = 1'($urandom_range(0, 1));
            end
            check({cfg, " results drained"}, 64'(got), 64'(NOPS));
            done = 1'b1;
        end
    end

    // ---------------- main sequence ----------------
    initial begin
        int cyc;
        bus0.in_valid = 1'b0; bus0.a = '0; bus0.b = '0; bus0.cin = 1'b0; bus0.sub = 1'b0;
        bus0.out_ready = 1'b0;
        rst = 1'b1;
        #1;
        check("reset out_valid", 64'(bus0.out_valid), 64'd0);
        check("reset s",         64'(bus0.s),         64'd0);
        check("reset cout",      64'(bus0.cout),      64'd0);
        check("reset ovf",       64'(bus0.ovf),       64'd0);
        check("reset in_ready",  64'(bus0.in_ready),  64'd1);
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;

        do_op("carry chain",  24'hFFFFFF, 24'h000001, 1'b0, 1'b0, 24'h000000, 1'b1, 1'b0);
        do_op("sub borrow",   24'h000010, 24'h000020, 1'b0, 1'b1, 24'hFFFFF0, 1'b0, 1'b0);
        do_op("sub overflow", 24'h800000, 24'h000001, 1'b0, 1'b1, 24'h7FFFFF, 1'b1, 1'b1);
        do_op("add overflow", 24'h7FFFFF, 24'h000001, 1'b0, 1'b0, 24'h800000, 1'b0, 1'b1);
        do_op("add cin",      24'h000005, 24'h000003, 1'b1, 1'b0, 24'h000009, 1'b0, 1'b0);

        // Reset with three operations in flight.
        bus0.out_ready = 1'b1;
        for (int i = 0; i < 3; i++) begin
            bus0.a = 24'h000123 + 24'(i) * 24'h111111;
            bus0.b = 24'h010101; bus0.cin = 1'b0; bus0.sub = 1'b0;
            bus0.in_valid = 1'b1;
            @(posedge clk); #1;
        end
        bus0.in_valid  = 1'b0;
        bus0.out_ready = 1'b0;
        check("pre-reset out_valid", 64'(bus0.out_valid), 64'd1);
        check("pre-reset s",         64'(bus0.s),         64'h010224);
        #2 rst = 1'b1;
        #1;
        check("async reset out_valid", 64'(bus0.out_valid), 64'd0);
        check("async reset s",         64'(bus0.s),         64'd0);
        check("async reset cout",      64'(bus0.cout),      64'd0);
        check("async reset ovf",       64'(bus0.ovf),       64'd0);
        check("async reset in_ready",  64'(bus0.in_ready),  64'd1);
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        do_op("post-reset", 24'h000001, 24'h000002, 1'b0, 1'b0, 24'h000003, 1'b0, 1'b0);
        check("post-reset drained", 64'(bus0.out_valid), 64'd0);

        start = 1'b1;
        cyc = 0;
        while (!(g_sweep[0].done && g_sweep[1].done && g_sweep[2].done && g_sweep[3].done)
               && cyc < 20000) begin
            @(posedge clk);
            cyc++;
        end
        check("sweep completed",
              64'(g_sweep[0].done && g_sweep[1].done && g_sweep[2].done && g_sweep[3].done),
              64'd1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
